uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (UartXmt-style: shift/load, clock enable, empty flag)

---
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ byte requesters; drives the DIV bit-clock enable and load/shift, acks each frame once it has left the line.
// Grant 1 cycle after req, load on the next bit tick, ack (9+GAP_BITS)*DIV cycles later; non-owners simply wait with req held.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int DIV      = 16,
    parameter int GAP_BITS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data_in,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [7:0]        xmt_data,
    output logic              xmt_shift_ld,
    output logic              xmt_enable,
    input  logic              xmt_empty
);
    localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW      = $clog2(DIV);
    localparam int GAP_EFF = (GAP_BITS < 1) ? 1 : GAP_BITS;
    localparam int GW      = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} stateT;

    stateT         state;
    stateT         stateNext;
    logic [DW-1:0] divCnt;
    logic          tick;
    logic [PW-1:0] rrPtr;
    logic [GW-1:0] gapCnt;
    logic          pickValid;
    logic [PW-1:0] pickIdx;
    logic [PW-1:0] scanIdx;
    logic          startXfer;
    logic          doneXfer;

    assign tick         = (divCnt == DW'(DIV - 1));
    assign xmt_enable   = tick;
    assign busy         = (state != IDLE);
    assign xmt_shift_ld = (state != LOAD);

    always_ff @(posedge clock) begin
        if (reset) begin
            divCnt <= '0;
        end else if (tick) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    // Scan starts just past the last owner, so a requester that was just served comes last.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        scanIdx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scanIdx = PW'((int'(rrPtr) + k) % NREQ);
            if (!pickValid && req[scanIdx]) begin
                pickValid = 1'b1;
                pickIdx   = scanIdx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // No arbitration in the ack cycle: the acked requester may not have dropped req yet.
    always_comb begin
        stateNext = state;
        startXfer = 1'b0;
        doneXfer  = 1'b0;
        case (state)
            IDLE: begin
                if (pickValid && (ack == '0)) begin
                    stateNext = LOAD;
                    startXfer = 1'b1;
                end
            end
            LOAD: begin
                if (tick) begin
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (tick && xmt_empty) begin
                    stateNext = GAP;
                end
            end
            GAP: begin
                if (tick && (gapCnt == GW'(GAP_EFF - 1))) begin
                    stateNext = IDLE;
                    doneXfer  = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant    <= '0;
            ack      <= '0;
            xmt_data <= '0;
            rrPtr    <= PW'(NREQ - 1);
            gapCnt   <= '0;
        end else begin
            ack <= '0;
            if (startXfer) begin
                grant    <= NREQ'(1) << pickIdx;
                xmt_data <= data_in[{pickIdx, 3'b000} +: 8];
                rrPtr    <= pickIdx;
            end
            if (state == SEND) begin
                gapCnt <= '0;
            end else if ((state == GAP) && tick) begin
                gapCnt <= gapCnt + 1'b1;
            end
            if (doneXfer) begin
                ack   <= grant;
                grant <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with an attached transmitter model and a frame-timing reference model.
module tb_uart_tx_arbiter;
    localparam int NREQ      = 4;
    localparam int DIV       = 16;
    localparam int GAP_BITS  = 1;
    localparam int GAP_EFF   = (GAP_BITS < 1) ? 1 : GAP_BITS;
    localparam int FRAME_CYC = (9 + GAP_EFF) * DIV;

    logic              clock   = 1'b0;
    logic              reset   = 1'b1;
    logic [NREQ-1:0]   req     = '0;
    logic [8*NREQ-1:0] data_in = '0;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic [7:0]        xmt_data;
    logic              xmt_shift_ld;
    logic              xmt_enable;
    logic              xmt_empty;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.NREQ(NREQ), .DIV(DIV), .GAP_BITS(GAP_BITS)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .data_in      (data_in),
        .grant        (grant),
        .ack          (ack),
        .busy         (busy),
        .xmt_data     (xmt_data),
        .xmt_shift_ld (xmt_shift_ld),
        .xmt_enable   (xmt_enable),
        .xmt_empty    (xmt_empty)
    );

    // Transmitter: load puts the start bit out, 8 shifts put out data, empty once the last data bit is out.
    logic       xmtResetN;
    int         txSent = 9;
    logic       txLine = 1'b1;
    logic [7:0] txByte = '0;
    assign xmtResetN = ~reset;
    assign xmt_empty = (txSent == 9);

    always @(posedge clock) begin
        if (!xmtResetN) begin
            txSent <= 9;
            txLine <= 1'b1;
        end else if (xmt_enable) begin
            if (!xmt_shift_ld) begin
                txByte <= xmt_data;
                txSent <= 1;
                txLine <= 1'b0;
            end else if (txSent < 9) begin
                txLine <= txByte[txSent-1];
                txSent <= txSent + 1;
            end else begin
                txLine <= 1'b1;
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nChecks++;
        if (obs !== want) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, want, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pickNext(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return 0;
    endfunction

    // Reference model: each frame's timeline follows from the grant cycle and the free-running bit tick.
    int                cyc = 0;
    int                mDiv = 0;
    int                mOwner = 0;
    int                mLast = NREQ - 1;
    int                mLoadEdge = -1;
    bit                mActive = 1'b0;
    bit                mAckNow = 1'b0;
    bit                ackPrev;
    bit                prevEn;
    logic [7:0]        mByte = '0;
    logic              pReset = 1'b1;
    logic [NREQ-1:0]   pReq = '0;
    logic [8*NREQ-1:0] pData = '0;

    always @(negedge clock) begin
        logic [9:0] frame;
        int         bitIdx;
        cyc++;
        if (pReset) begin
            mDiv      = 0;
            mActive   = 1'b0;
            mAckNow   = 1'b0;
            mLast     = NREQ - 1;
            mLoadEdge = -1;
            checkVal("rst_data", xmt_data, 0);
        end else begin
            prevEn  = (mDiv == DIV - 1);
            mDiv    = (mDiv + 1) % DIV;
            ackPrev = mAckNow;
            mAckNow = 1'b0;
            if (mActive) begin
                if (mLoadEdge < 0 && prevEn) mLoadEdge = cyc;
                if (mLoadEdge >= 0 && cyc == mLoadEdge + FRAME_CYC) begin
                    mActive = 1'b0;
                    mAckNow = 1'b1;
                end
            end else if (!ackPrev && pReq != '0) begin
                mOwner    = pickNext(pReq, mLast);
                mLast     = mOwner;
                mActive   = 1'b1;
                mLoadEdge = -1;
                mByte     = pData[8*mOwner +: 8];
                checkVal("grant_data", xmt_data, mByte);
            end
        end
        checkVal("grant", grant, mActive ? onehot(mOwner) : '0);
        checkVal("ack", ack, mAckNow ? onehot(mOwner) : '0);
        checkVal("busy", busy, mActive);
        checkVal("shift_ld", xmt_shift_ld, !(mActive && mLoadEdge < 0));
        checkVal("enable", xmt_enable, mDiv == DIV - 1);
        frame  = {1'b1, mByte, 1'b0};
        bitIdx = (mActive && mLoadEdge >= 0) ? (cyc - mLoadEdge) / DIV : -1;
        checkVal("line", txLine, (bitIdx >= 0 && bitIdx <= 9) ? frame[bitIdx] : 1'b1);
        pReset = reset;
        pReq   = req;
        pData  = data_in;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseReset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic waitGrant(output logic [NREQ-1:0] g);
        int n = 0;
        while (grant == '0 && n < 2000) begin
            step();
            n++;
        end
        checkVal("grant_timeout", n < 2000, 1);
        g = grant;
    endtask

    task automatic waitAck(output logic [NREQ-1:0] a);
        int n = 0;
        while (ack == '0 && n < 2000) begin
            step();
            n++;
        end
        checkVal("ack_timeout", n < 2000, 1);
        a = ack;
    endtask

    task automatic waitSend();
        int n = 0;
        while (!(busy && xmt_shift_ld) && n < 200) begin
            step();
            n++;
        end
        checkVal("send_timeout", n < 200, 1);
    endtask

    initial begin
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] a;
        int              enCnt;

        pulseReset(3);

        // single request, byte A5
        data_in[7:0] = 8'hA5;
        req          = 4'b0001;
        step();
        checkVal("t1_grant", grant, 4'b0001);
        waitAck(a);
        checkVal("t1_ack", a, 4'b0001);
        req = '0;
        step();
        checkVal("t1_ack_pulse", ack, 4'b0000);

        // all requesting from reset: round-robin order 0,1,2,3,0
        pulseReset(2);
        for (int i = 0; i < NREQ; i++) data_in[8*i +: 8] = 8'($urandom);
        req = '1;
        for (int r = 0; r < 5; r++) begin
            waitGrant(g);
            checkVal("t2_order", g, onehot(r % NREQ));
            waitAck(a);
            checkVal("t2_ack", a, g);
        end
        req = '0;
        repeat (3) step();

        // two requesters with extreme bytes
        pulseReset(2);
        data_in[7:0]   = 8'h00;
        data_in[23:16] = 8'hFF;
        req            = 4'b0101;
        waitGrant(g);
        checkVal("t3_grant0", g, 4'b0001);
        checkVal("t3_data0", xmt_data, 8'h00);
        waitAck(a);
        checkVal("t3_ack0", a, 4'b0001);
        req[0] = 1'b0;
        waitGrant(g);
        checkVal("t3_grant2", g, 4'b0100);
        checkVal("t3_data2", xmt_data, 8'hFF);
        waitAck(a);
        checkVal("t3_ack2", a, 4'b0100);
        req = '0;
        repeat (3) step();

        // reset in the middle of req1's frame
        data_in[15:8] = 8'h5A;
        req           = 4'b0010;
        waitGrant(g);
        checkVal("t4_grant", g, 4'b0010);
        waitSend();
        repeat (3 * DIV) step();
        pulseReset(1);
        checkVal("t4_rst_grant", grant, 4'b0000);
        checkVal("t4_rst_busy", busy, 1'b0);
        checkVal("t4_rst_shld", xmt_shift_ld, 1'b1);
        checkVal("t4_rst_ack", ack, 4'b0000);
        repeat (DIV - 2) step();
        checkVal("t4_en_early", xmt_enable, 1'b0);
        step();
        checkVal("t4_en_phase", xmt_enable, 1'b1);
        waitGrant(g);
        checkVal("t4_regrant", g, 4'b0010);
        waitAck(a);
        checkVal("t4_ack", a, 4'b0010);
        req = '0;
        repeat (3) step();

        // owner drops req and changes its byte during SEND
        data_in[7:0] = 8'h3C;
        req          = 4'b0001;
        waitGrant(g);
        checkVal("t5_grant", g, 4'b0001);
        waitSend();
        data_in[7:0] = 8'hC3;
        req          = '0;
        waitAck(a);
        checkVal("t5_ack", a, 4'b0001);

        // idle line
        req   = '0;
        enCnt = 0;
        repeat (100) begin
            step();
            if (xmt_enable) enCnt++;
        end
        checkVal("t6_en_count", (enCnt == 6 || enCnt == 7), 1);
        checkVal("t6_busy", busy, 1'b0);
        checkVal("t6_shld", xmt_shift_ld, 1'b1);
        checkVal("t6_line", txLine, 1'b1);

        // random requesters, one reset mid-run
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) req[i] = ($urandom_range(3) == 0);
                else if (!req[i] && $urandom_range(7) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(199) == 0) req[i] = 1'b0;
                if ($urandom_range(15) == 0) data_in[8*i +: 8] = 8'($urandom);
            end
            reset = (c == 2500);
            step();
        end
        reset = 1'b0;
        req   = '0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule
